// File: rtl/fir_pkg.sv
// Shared fixed-point types and the Q2.30 -> Q1.15 round-half-up/saturate helper
// used by the FIR output stages.
package fir_pkg;

  localparam int unsigned ACC_W      = 32;
  localparam int unsigned OUT_W      = 16;
  localparam int unsigned FRAC_SHIFT = 15;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] sample_t;

  typedef struct packed {
    acc_t s0;
    acc_t s1;
    acc_t s2;
  } triplet_t;

  typedef struct packed {
    logic    sat;
    sample_t data;
  } rs_t;

  typedef enum logic [1:0] {Ph0, Ph1, Ph2} phase_e;

  // Constants are one bit wider than acc_t so the rounding add cannot overflow.
  localparam logic signed [ACC_W:0] RoundC =
    {{(ACC_W + 1 - FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT - 1){1'b0}}};
  localparam logic signed [ACC_W:0] SatMax =
    {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SatMin =
    {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  function automatic rs_t round_sat(acc_t x);
    logic signed [ACC_W:0] t;
    rs_t                   r;
    t = $signed({x[ACC_W-1], x}) + RoundC;
    t = t >>> FRAC_SHIFT;
    if (t > SatMax) begin
      r.sat  = 1'b1;
      r.data = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (t < SatMin) begin
      r.sat  = 1'b1;
      r.data = {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      r.sat  = 1'b0;
      r.data = t[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_triplet_fifo.sv
// Small synchronous FIFO of polyphase triplets; pointers carry one extra wrap bit
// so full and empty are told apart by the MSB compare.
module fir_triplet_fifo
  import fir_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  triplet_t wdata_i,
  input  logic     pop_i,
  output triplet_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  triplet_t            mem_q [Depth];
  logic     [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic     [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic                do_push, do_pop;

  assign full_o  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/fir_3to1_serializer.sv
// Serialises buffered polyphase triplets (y0,y1,y2) into one rate-1 Q1.15 stream
// with round-half-up, saturation and a valid/ready output handshake.
module fir_3to1_serializer
  import fir_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] y0,
  input  logic [ACC_W-1:0] y1,
  input  logic [ACC_W-1:0] y2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_count
);

  triplet_t         wr_trip;
  triplet_t         head;
  logic             fifo_full, fifo_empty;
  logic             load, pop;
  acc_t             sel_acc;
  rs_t              quant;

  phase_e           phase_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_sat_q;
  logic [CNT_W-1:0] sat_cnt_q;
  logic             out_fire;

  assign wr_trip  = '{s0: y0, s1: y1, s2: y2};
  // No pass-through: a pop in this cycle does not free a slot for this push.
  assign in_ready = !fifo_full;

  assign load     = !fifo_empty && (!out_valid_q || out_ready);
  assign pop      = load && (phase_q == Ph2);
  assign out_fire = out_valid_q && out_ready;

  fir_triplet_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .wdata_i (wr_trip),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    sel_acc = head.s0;
    unique case (phase_q)
      Ph1:     sel_acc = head.s1;
      Ph2:     sel_acc = head.s2;
      default: sel_acc = head.s0;
    endcase
  end

  assign quant = round_sat(sel_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= Ph0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= quant.data;
      out_sat_q   <= quant.sat;
      unique case (phase_q)
        Ph0:     phase_q <= Ph1;
        Ph1:     phase_q <= Ph2;
        default: phase_q <= Ph0;
      endcase
    end else if (out_fire) begin
      // Drained: drop valid but keep the last sample on the bus.
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else if (out_fire && out_sat_q && (sat_cnt_q != {CNT_W{1'b1}})) begin
      sat_cnt_q <= sat_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_fir_3to1_serializer.sv
// Directed and randomised checks of the 3:1 serialiser against a small integer model.
module tb_fir_3to1_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y0, y1, y2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic [15:0] sat_count;

  int total = 0;
  int bad   = 0;

  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];

  fir_3to1_serializer #(
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) obs_q.push_back({out_sat, out_data});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Integer reference: round half up, arithmetic shift, clamp to Q1.15.
  function automatic logic [16:0] rs_model(input logic [31:0] x);
    longint t;
    t = longint'($signed(x));
    t = (t + 16384) >>> 15;
    if (t > 32767)  return {1'b1, 16'h7FFF};
    if (t < -32768) return {1'b1, 16'h8000};
    return {1'b0, t[15:0]};
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: begin
        v = $urandom & 32'h000F_FFFF;
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      2: v = 32'h3FFF_C000 + 32'($urandom_range(0, 4)) - 32'd2;
      default: v = 32'hC000_0000 + 32'($urandom_range(0, 40000)) - 32'd20000;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (obs_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic do_reset();
    tick();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({out_valid, out_sat, out_data, sat_count, in_ready} !== {2'b00, 16'h0, 16'h0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got v=%b s=%b d=%h cnt=%h rdy=%b want v=0 s=0 d=0000 cnt=0000 rdy=1",
               out_valid, out_sat, out_data, sat_count, in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rounding();
    logic [15:0] exp_d[3];
    exp_d = '{16'h0001, 16'h0000, 16'hFFFF};
    out_ready = 1'b1;
    y0 = 32'h0000_4000; y1 = 32'h0000_3FFF; y2 = 32'hFFFF_BFFF;
    in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL round_in_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL round_latency: got out_valid=%b want 0 on accept cycle", out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({out_valid, out_sat, out_data} !== {2'b10, exp_d[i]}) begin
        bad++;
        $display("FAIL round_s%0d: got v=%b s=%b d=%h want v=1 s=0 d=%h",
                 i, out_valid, out_sat, out_data, exp_d[i]);
      end
    end
    tick();
    total++;
    if ({out_valid, out_data} !== {1'b0, 16'hFFFF}) begin
      bad++; $display("FAIL round_drain: got v=%b d=%h want v=0 d=ffff", out_valid, out_data);
    end
  endtask

  task automatic test_saturation();
    logic [16:0] exp_d[3];
    exp_d = '{{1'b1, 16'h7FFF}, {1'b1, 16'h8000}, {1'b0, 16'h0000}};
    out_ready = 1'b1;
    y0 = 32'h7FFF_FFFF; y1 = 32'h8000_0000; y2 = 32'hFFFF_C000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({out_valid, out_sat, out_data} !== {1'b1, exp_d[i]}) begin
        bad++;
        $display("FAIL sat_s%0d: got v=%b s=%b d=%h want v=1 s=%b d=%h",
                 i, out_valid, out_sat, out_data, exp_d[i][16], exp_d[i][15:0]);
      end
    end
    tick();
    total++;
    if (sat_count !== 16'd2) begin
      bad++; $display("FAIL sat_count: got %0d want 2", sat_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    obs_q.delete();
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      y0 = 32'(((i * 3) + 1) * 40000 - 200000);
      y1 = 32'(((i * 3) + 2) * 40000 - 200000);
      y2 = 32'(((i * 3) + 3) * 40000 - 200000);
      in_valid = 1'b1;
      total++;
      if (in_ready !== (i < 4)) begin
        bad++; $display("FAIL bp_in_ready_%0d: got %b want %b", i, in_ready, (i < 4));
      end
      if (i < 4) begin
        exp_q.push_back(rs_model(y0));
        exp_q.push_back(rs_model(y1));
        exp_q.push_back(rs_model(y2));
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    total++;
    if ({out_valid, out_sat, out_data, in_ready} !== {1'b1, exp_q[0], 1'b0}) begin
      bad++;
      $display("FAIL bp_hold: got v=%b sd=%h rdy=%b want v=1 sd=%h rdy=0",
               out_valid, {out_sat, out_data}, in_ready, exp_q[0]);
    end
    out_ready = 1'b1;
    wait_obs(12, 100, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL bp_timeout: got %0d samples want 12", obs_q.size());
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_empty_valid: got %b want 0", out_valid);
    end
    tick();
    tick();
    total++;
    if (obs_q.size() != 12) begin
      bad++; $display("FAIL bp_count: got %0d want 12", obs_q.size());
    end
    for (int i = 0; i < 12 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_sample_%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    obs_q.delete();
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if ((c % 3 == 0) && (c / 3 < 6)) begin
        y0 = rand_val(); y1 = rand_val(); y2 = rand_val();
        exp_q.push_back(rs_model(y0));
        exp_q.push_back(rs_model(y1));
        exp_q.push_back(rs_model(y2));
        in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_in_ready_c%0d: got %b want 1", c, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 2 && c <= 19) begin
        total++;
        if (out_valid !== 1'b1) begin
          bad++; $display("FAIL b2b_gap_c%0d: got out_valid=%b want 1", c, out_valid);
        end
      end
      if (c == 20) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++; $display("FAIL b2b_end: got out_valid=%b want 0", out_valid);
        end
      end
      if (c < 20) tick();
    end
    in_valid = 1'b0;
    wait_obs(18, 20, ok);
    total++;
    if (!ok || obs_q.size() != 18) begin
      bad++; $display("FAIL b2b_count: got %0d want 18", obs_q.size());
    end
    for (int i = 0; i < 18 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_sample_%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] tv[200][3];
    int          idx, cyc, model_sat, nerr;
    bit          acc;
    do_reset();
    model_sat = 0;
    for (int i = 0; i < 200; i++) begin
      for (int j = 0; j < 3; j++) begin
        tv[i][j] = rand_val();
        exp_q.push_back(rs_model(tv[i][j]));
        if (rs_model(tv[i][j]) >= 17'h10000) model_sat++;
      end
    end
    idx = 0;
    cyc = 0;
    while ((idx < 200 || obs_q.size() < 600) && cyc < 5000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (idx < 200 && $urandom_range(0, 4) != 0) begin
        in_valid = 1'b1;
        y0 = tv[idx][0]; y1 = tv[idx][1]; y2 = tv[idx][2];
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    total++;
    if (obs_q.size() != 600) begin
      bad++; $display("FAIL rnd_count: got %0d want 600", obs_q.size());
    end
    nerr = 0;
    for (int i = 0; i < 600 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        nerr++;
        if (nerr <= 10) $display("FAIL rnd_sample_%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (sat_count !== 16'(model_sat)) begin
      bad++; $display("FAIL rnd_sat_count: got %0d want %0d", sat_count, model_sat);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    out_ready = 1'b1;
    y0 = 32'h7FFF_FFFF; y1 = 32'h0001_0000; y2 = 32'h0002_0000;
    in_valid = 1'b1;
    tick();
    y0 = 32'h0003_0000; y1 = 32'h0004_0000; y2 = 32'h0005_0000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    total++;
    if (obs_q.size() != 2 || sat_count !== 16'd1) begin
      bad++; $display("FAIL mid_pre: got n=%0d cnt=%0d want n=2 cnt=1", obs_q.size(), sat_count);
    end
    rst_n = 1'b0;
    #2;
    total++;
    if ({out_valid, out_sat, out_data, sat_count, in_ready} !== {2'b00, 16'h0, 16'h0, 1'b1}) begin
      bad++;
      $display("FAIL mid_async_reset: got v=%b s=%b d=%h cnt=%h rdy=%b want v=0 s=0 d=0000 cnt=0000 rdy=1",
               out_valid, out_sat, out_data, sat_count, in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    obs_q.delete();
    exp_q.delete();
    y0 = 32'h0001_8000; y1 = 32'hFFFE_0000; y2 = 32'h0000_C000;
    exp_q.push_back(rs_model(y0));
    exp_q.push_back(rs_model(y1));
    exp_q.push_back(rs_model(y2));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_obs(3, 20, ok);
    tick();
    tick();
    tick();
    total++;
    if (!ok || obs_q.size() != 3 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_after_count: got n=%0d v=%b want n=3 v=0", obs_q.size(), out_valid);
    end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL mid_sample_%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    y0 = '0; y1 = '0; y2 = '0;
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_3to1_serializer.md
Name: fir_3to1_serializer

Overview:
- Downstream of the 3-path parallel FIR.
- Accepts one triplet of 32-bit Q2.30 polyphase results (y(3k), y(3k+1), y(3k+2)) per handshake and buffers triplets in a small FIFO.
- Emits them as a single 16-bit Q1.15 sample stream in time order, with round-half-up, saturation and a valid/ready output handshake.
- Produces the rate-1 output stream consumed by the DAC/capture logic.

Parameters:
ACC_W, 32, input sample width (Q2.30 filter sums)
OUT_W, 16, output sample width (Q1.15)
FRAC_SHIFT, 15, right-shift applied before saturation
FIFO_DEPTH, 4, triplet FIFO entries (power of 2, >=2)
CNT_W, 16, saturation event counter width

Ports:
clk  in  1  system clock
rst_n  in  1  reset
in_valid  in  1  triplet y0/y1/y2 valid
in_ready  out  1  FIFO can accept a triplet
y0  in  ACC_W  signed, time index 3k
y1  in  ACC_W  signed, time index 3k+1
y2  in  ACC_W  signed, time index 3k+2
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
out_data  out  OUT_W  signed Q1.15 sample
out_sat  out  1  qualifies out_data; 1 = sample was clipped
sat_count  out  CNT_W  clipped samples emitted since reset, sticks at max

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset values: FIFO empty, phase=0, out_valid=0, out_data=0, out_sat=0, sat_count=0, in_ready=1 (in_ready is combinational !full).
- Input push: when in_valid && in_ready at a clk edge, the raw triplet is written at wr_ptr.
  - in_ready = !full and ignores a same-cycle pop, so no pass-through path exists.
  - If in_valid is asserted while full, nothing is written. Upstream must hold or drop; the block does not flag this.
- Output register load condition: load = !empty && (!out_valid || out_ready).
  - On load: out_data/out_sat = quantize(head[phase]), out_valid=1.
  - phase advances 0->1->2->0. When phase==2 the head is popped (rd_ptr++).
  - If out_valid && out_ready && empty: out_valid clears. out_data holds its last value.
  - While out_valid && !out_ready, out_data, out_sat and phase are stable.
- Emit order: y0, y1, y2 of a triplet, then y0 of the next triplet. No gaps while data is available and out_ready=1.
- Latency: triplet accepted at edge N with the FIFO empty gives first out_valid after edge N+1, and y1, y2 after N+2, N+3.
- Throughput: 1 sample/clk out; sustained input 1 triplet per 3 clk.
- Simultaneous push and pop (phase==2 load) in one cycle: both occur; count unchanged.
- Pointers are log2(FIFO_DEPTH)+1 bits. Full/empty are decided by the MSB compare and wrap naturally.
- Quantize (combinational, on the FIFO head word):
  - t = sign-extend to ACC_W+1 bits.
  - t = t + 2^(FRAC_SHIFT-1).
  - t = t >>> FRAC_SHIFT (arithmetic shift).
  - If t > 2^(OUT_W-1)-1, result = 0x7FFF and sat=1.
  - If t < -2^(OUT_W-1), result = 0x8000 and sat=1.
  - Otherwise result = t[OUT_W-1:0] and sat=0.
- sat_count increments once per output handshake (out_valid && out_ready) with out_sat=1. It saturates at all-ones.
- Reset mid-operation: everything returns to reset values immediately; any partially emitted triplet is discarded.

Decomposition:
- Shared package fir_pkg: ACC_W, OUT_W, FRAC_SHIFT defaults; acc_t/sample_t typedefs; triplet_t struct {acc_t s0,s1,s2}; function round_sat(acc_t) returning {sat, sample_t}. The same rounding will be reused by later stages.
- One sub-module: fir_triplet_fifo (parameterised depth, triplet_t data, push/pop/full/empty, async active-low reset).
- Phase counter, output register and sat counter stay in the top module.

Test Plan:
- Rounding, one triplet y0=0x00004000, y1=0x00003FFF, y2=0xFFFFBFFF, out_ready=1 -> out_data 0x0001, 0x0000, 0xFFFF on consecutive cycles; first valid 1 clk after accept; out_sat=0 throughout.
- Saturation: y0=0x7FFFFFFF, y1=0x80000000, y2=0xFFFFC000 -> 0x7FFF(sat=1), 0x8000(sat=1), 0x0000(sat=0); sat_count=2.
- Backpressure and full: out_ready=0, push 5 triplets back-to-back -> in_ready low after 4 accepted (the 5th is not written), out_valid=1 holding the first y0; release out_ready -> 12 samples in order, no duplicates or gaps.
- Sustained stream: a new triplet every 3 clk, out_ready=1 -> out_valid continuously high after the first, count never exceeds 1, sequence matches the reference model.
- Random out_ready toggling with 200 random triplets -> output equals the scoreboard (round_sat of y0,y1,y2 in order); sat_count matches the model.
- Reset mid-triplet: assert rst_n=0 after y1 is emitted -> out_valid=0, sat_count=0, in_ready=1 asynchronously; after release, a new triplet emits from its y0.
